// File: rtl/usb_rx_unstuff_sync_pkg.sv
// usb_rx_pkg: shared state encoding and default framing constants for the USB receive unstuff/sync stage.
package usb_rx_pkg;
   typedef enum logic [1:0] {IDLE, DATA, ERROR} state_t;
   localparam logic [7:0] DEF_SYNC_PATTERN = 8'h80;
   localparam int DEF_STUFF_LEN = 6;
   localparam int BYTE_BITS = 8;
endpackage

// File: rtl/usb_rx_unstuff_sync_if.sv
// usb_rx_unstuff_sync_if: decoded-bit input side and byte/status output side of the receive stage.
interface usb_rx_unstuff_sync_if;
   logic       en;
   logic       d_orig;
   logic       eop;
   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       sync_found;
   logic       rx_active;
   logic       stuff_err;
   logic       align_err;
   logic       eop_done;
   modport master (output en, d_orig, eop,
                   input rx_byte, byte_valid, sync_found, rx_active, stuff_err, align_err, eop_done);
   modport slave (input en, d_orig, eop,
                  output rx_byte, byte_valid, sync_found, rx_active, stuff_err, align_err, eop_done);
endinterface

// File: rtl/usb_rx_unstuff_sync_bit_unstuff.sv
// usb_rx_bit_unstuff: run-length counter of 1s that flags the stuffed bit slot and stuffing violations.
module usb_rx_bit_unstuff
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN = DEF_STUFF_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_step,
   input  logic i_d,
   output logic o_bit_keep,
   output logic o_stuff_violation
);
   localparam int CW = $clog2(STUFF_LEN + 1);
   logic [CW-1:0] r_ones_cnt;
   logic          w_full;
   assign w_full            = r_ones_cnt == CW'(STUFF_LEN);
   assign o_bit_keep        = !w_full;
   assign o_stuff_violation = w_full && i_d;
   // the stuffed slot always clears the run; a 1 there is an error and the count no longer matters
   always_ff @(posedge clk)
      if (rst) r_ones_cnt <= '0;
      else if (i_load) r_ones_cnt <= CW'(1);
      else if (i_step) r_ones_cnt <= (i_d && !w_full) ? r_ones_cnt + 1'b1 : '0;
endmodule

// File: rtl/usb_rx_unstuff_sync.sv
// usb_rx_unstuff_sync: finds SYNC, strips stuffed bits, assembles LSB-first bytes and reports EOP/framing status.
module usb_rx_unstuff_sync
   import usb_rx_pkg::*;
#(
   parameter logic [7:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
   parameter int         STUFF_LEN    = DEF_STUFF_LEN
) (
   input logic                   clk,
   input logic                   rst,
   usb_rx_unstuff_sync_if.slave  io_rx
);
   state_t     r_state, w_next;
   logic [6:0] r_sync_sh;
   logic [6:0] r_data_sh;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_rx_byte;
   logic       r_byte_valid, r_sync_found, r_rx_active, r_stuff_err, r_align_err, r_eop_done;
   logic [7:0] w_sync_next;
   logic       w_sync_hit, w_data_en, w_keep, w_stuff, w_byte, w_eop_data;
   logic       w_bit_keep, w_stuff_viol;
   usb_rx_bit_unstuff #(.STUFF_LEN(STUFF_LEN)) u_unstuff (
      .clk               (clk),
      .rst               (rst),
      .i_load            (w_sync_hit),
      .i_step            (w_data_en),
      .i_d               (io_rx.d_orig),
      .o_bit_keep        (w_bit_keep),
      .o_stuff_violation (w_stuff_viol)
   );
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   always_comb
      w_next = (r_state == IDLE) ? (w_sync_hit ? DATA : IDLE)
             : io_rx.eop         ? IDLE
             : w_stuff           ? ERROR
             :                     r_state;
   // shifters keep only the upper 7 bits; the bit shifted out is never observed
   always_comb begin
      w_sync_next = {io_rx.d_orig, r_sync_sh};
      w_sync_hit  = r_state == IDLE && io_rx.en && !io_rx.eop && w_sync_next == SYNC_PATTERN;
      w_data_en   = r_state == DATA && io_rx.en && !io_rx.eop;
      w_keep      = w_data_en && w_bit_keep;
      w_stuff     = w_data_en && w_stuff_viol;
      w_byte      = w_keep && r_bit_cnt == 3'(BYTE_BITS - 1);
      w_eop_data  = r_state == DATA && io_rx.eop;
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_sync_sh    <= '1;
         r_data_sh    <= '0;
         r_bit_cnt    <= '0;
         r_rx_byte    <= '0;
         r_byte_valid <= 1'b0;
         r_sync_found <= 1'b0;
         r_rx_active  <= 1'b0;
         r_stuff_err  <= 1'b0;
         r_align_err  <= 1'b0;
         r_eop_done   <= 1'b0;
      end else begin
         r_sync_found <= w_sync_hit;
         r_byte_valid <= w_byte;
         r_stuff_err  <= w_stuff;
         r_eop_done   <= w_eop_data && r_bit_cnt == '0;
         r_align_err  <= w_eop_data && r_bit_cnt != '0;
         r_rx_active  <= w_next != IDLE;
         if (r_state != IDLE && io_rx.eop) r_sync_sh <= '1;
         else if (r_state == IDLE && io_rx.en && !io_rx.eop) r_sync_sh <= w_sync_next[7:1];
         if (w_keep) r_data_sh <= {io_rx.d_orig, r_data_sh[6:1]};
         if (w_byte) r_rx_byte <= {io_rx.d_orig, r_data_sh};
         if (w_sync_hit) r_bit_cnt <= '0;
         else if (w_keep) r_bit_cnt <= w_byte ? '0 : r_bit_cnt + 1'b1;
      end
   assign io_rx.rx_byte    = r_rx_byte;
   assign io_rx.byte_valid = r_byte_valid;
   assign io_rx.sync_found = r_sync_found;
   assign io_rx.rx_active  = r_rx_active;
   assign io_rx.stuff_err  = r_stuff_err;
   assign io_rx.align_err  = r_align_err;
   assign io_rx.eop_done   = r_eop_done;
endmodule

// File: tb/tb_usb_rx_unstuff_sync.sv
// tb_usb_rx_unstuff_sync: scoreboard bench; expected status events are queued as stimulus is driven.
module tb_usb_rx_unstuff_sync;
   localparam logic [7:0] K_SYNC = 8'd1, K_BYTE = 8'd2, K_STUFF = 8'd3, K_ALIGN = 8'd4, K_EOP = 8'd5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0, n_err = 0, gap = 0;
   logic [15:0] exp_q[$];
   usb_rx_unstuff_sync_if rx();
   usb_rx_unstuff_sync dut (.clk(clk), .rst(rst), .io_rx(rx));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic expect_ev(input logic [7:0] k, input logic [7:0] b);
      exp_q.push_back({k, b});
   endtask
   task automatic take(input logic [15:0] ev);
      if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 32'd0);
      else check("event", 32'(ev), 32'(exp_q.pop_front()));
   endtask
   always @(negedge clk) begin
      if (rx.sync_found) take({K_SYNC, 8'h00});
      if (rx.byte_valid) take({K_BYTE, rx.rx_byte});
      if (rx.stuff_err)  take({K_STUFF, 8'h00});
      if (rx.align_err)  take({K_ALIGN, 8'h00});
      if (rx.eop_done)   take({K_EOP, 8'h00});
   end
   task automatic strobe(input logic b, input logic e);
      @(negedge clk);
      rx.en = 1'b1; rx.d_orig = b; rx.eop = e;
      @(negedge clk);
      rx.en = 1'b0; rx.eop = 1'b0;
      repeat (gap) begin
         rx.d_orig = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
   endtask
   task automatic send_sync();
      repeat (3) strobe(1'b1, 1'b0);
      repeat (7) strobe(1'b0, 1'b0);
      expect_ev(K_SYNC, 8'h00);
      strobe(1'b1, 1'b0);
      check("rx_active_after_sync", 32'(rx.rx_active), 32'd1);
   endtask
   task automatic send_byte(input logic [7:0] b, input bit produce);
      for (int i = 0; i < 8; i++) begin
         if (i == 7 && produce) expect_ev(K_BYTE, b);
         strobe(b[i], 1'b0);
      end
   endtask
   task automatic end_pkt(input logic [7:0] k);
      if (k != 8'd0) expect_ev(k, 8'h00);
      @(negedge clk);
      rx.eop = 1'b1;
      @(negedge clk);
      rx.eop = 1'b0;
      check("rx_active_after_eop", 32'(rx.rx_active), 32'd0);
   endtask
   task automatic check_quiet(input string tag);
      check({tag, "_rx_byte"}, 32'(rx.rx_byte), 32'h00);
      check({tag, "_rx_active"}, 32'(rx.rx_active), 32'd0);
      check({tag, "_pulses"}, 32'({rx.byte_valid, rx.sync_found, rx.stuff_err, rx.align_err, rx.eop_done}), 32'd0);
   endtask
   initial begin
      rx.en = 1'b0; rx.d_orig = 1'b1; rx.eop = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;
      send_sync();
      send_byte(8'hA5, 1'b1);
      end_pkt(K_EOP);
      check("rx_byte_hold", 32'(rx.rx_byte), 32'hA5);
      send_sync();
      repeat (5) strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b0);
      repeat (2) strobe(1'b1, 1'b0);
      expect_ev(K_BYTE, 8'hFF);
      strobe(1'b1, 1'b0);
      end_pkt(K_EOP);
      send_sync();
      repeat (5) strobe(1'b1, 1'b0);
      expect_ev(K_STUFF, 8'h00);
      strobe(1'b1, 1'b0);
      send_byte(8'h00, 1'b0);
      check("rx_active_in_error", 32'(rx.rx_active), 32'd1);
      end_pkt(8'd0);
      send_sync();
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0);
      end_pkt(K_ALIGN);
      send_sync();
      send_byte(8'h5A, 1'b1);
      expect_ev(K_EOP, 8'h00);
      strobe(1'b1, 1'b1);
      check("rx_active_en_eop", 32'(rx.rx_active), 32'd0);
      check("rx_byte_en_eop", 32'(rx.rx_byte), 32'h5A);
      gap = 3;
      send_sync();
      send_byte(8'hA5, 1'b1);
      end_pkt(K_EOP);
      gap = 0;
      check("rx_byte_gated", 32'(rx.rx_byte), 32'hA5);
      send_sync();
      repeat (4) strobe(1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_quiet("mid_reset");
      send_sync();
      send_byte(8'h3C, 1'b1);
      end_pkt(K_EOP);
      check("rx_byte_after_reset", 32'(rx.rx_byte), 32'h3C);
      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
